wb_arbiter_2m: RTL

Two-master, one-slave Wishbone classic arbiter that shares the system bus between the PicoRV32 core (master 0) and a second bus master such as DMA or video fetch (master 1). It grants ownership per bus cycle (`cyc`), alternates fairly between the masters under contention, and routes the owner's signals to the slave side. A watchdog aborts any cycle the slave does not acknowledge, so the CPU cannot hang on an unmapped address. It sits between the CPU/DMA wrappers and the address decoder.

---
 rtl/wb_arbiter_2m_if.sv | 38 +++
 rtl/wb_arbiter_2m.sv | 105 ++++++++++
 2 files changed

// File: rtl/wb_arbiter_2m_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | wb_arbiter_2m_if - master/slave bundle for the 2-master arbiter   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface wb_arbiter_2m_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   m0_adr, m1_adr, s_adr;
  logic [DATA_W-1:0]   m0_dat_mosi, m1_dat_mosi, s_dat_mosi;
  logic [DATA_W-1:0]   m0_dat_miso, m1_dat_miso, s_dat_miso;
  logic [DATA_W/8-1:0] m0_sel, m1_sel, s_sel;
  logic                m0_we, m0_stb, m0_cyc, m0_ack, m0_err;
  logic                m1_we, m1_stb, m1_cyc, m1_ack, m1_err;
  logic                s_we, s_stb, s_cyc, s_ack;
  logic [1:0]          grant;
  logic [7:0]          abort_cnt;

  // Arbiter side
  modport slave (
    input  m0_adr, m0_dat_mosi, m0_sel, m0_we, m0_stb, m0_cyc,
    input  m1_adr, m1_dat_mosi, m1_sel, m1_we, m1_stb, m1_cyc,
    input  s_dat_miso, s_ack,
    output m0_dat_miso, m0_ack, m0_err, m1_dat_miso, m1_ack, m1_err,
    output s_adr, s_dat_mosi, s_sel, s_we, s_stb, s_cyc, grant, abort_cnt
  );

  // Environment side: both bus masters plus the shared slave
  modport master (
    output m0_adr, m0_dat_mosi, m0_sel, m0_we, m0_stb, m0_cyc,
    output m1_adr, m1_dat_mosi, m1_sel, m1_we, m1_stb, m1_cyc,
    output s_dat_miso, s_ack,
    input  m0_dat_miso, m0_ack, m0_err, m1_dat_miso, m1_ack, m1_err,
    input  s_adr, s_dat_mosi, s_sel, s_we, s_stb, s_cyc, grant, abort_cnt
  );
endinterface
`default_nettype wire

// File: rtl/wb_arbiter_2m.sv
`default_nettype none
// +------------------------------------------------------------------+
// | wb_arbiter_2m - fair 2-master Wishbone classic arbiter + watchdog |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module wb_arbiter_2m #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                TIMEOUT  = 255,
  parameter logic [DATA_W-1:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input wire             clk,
  input wire             rst_n,
  wb_arbiter_2m_if.slave bus
);
  localparam int                c_wd_w   = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [c_wd_w-1:0] c_wd_max = c_wd_w'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_t;

  state_t            r_state;
  logic [1:0]        r_grant;
  logic              r_last;
  logic [c_wd_w-1:0] r_wd;
  logic [7:0]        r_abort_cnt;

  logic w_own0, w_own1, w_own_cyc, w_own_stb, w_abort;

  assign w_own0    = (r_state == ST_OWN0);
  assign w_own1    = (r_state == ST_OWN1);
  assign w_own_cyc = (w_own0 & bus.m0_cyc) | (w_own1 & bus.m1_cyc);
  assign w_own_stb = (w_own0 & bus.m0_stb) | (w_own1 & bus.m1_stb);
  assign w_abort   = (TIMEOUT != 0) && w_own_stb && (r_wd == c_wd_max);

  always_comb begin
    bus.s_adr      = '0;
    bus.s_dat_mosi = '0;
    bus.s_sel      = '0;
    bus.s_we       = 1'b0;
    if (w_own0) begin
      bus.s_adr      = bus.m0_adr;
      bus.s_dat_mosi = bus.m0_dat_mosi;
      bus.s_sel      = bus.m0_sel;
      bus.s_we       = bus.m0_we;
    end else if (w_own1) begin
      bus.s_adr      = bus.m1_adr;
      bus.s_dat_mosi = bus.m1_dat_mosi;
      bus.s_sel      = bus.m1_sel;
      bus.s_we       = bus.m1_we;
    end
  end

  // The abort cycle hides the transfer from the slave and answers the owner itself
  assign bus.s_cyc       = w_own_cyc & ~w_abort;
  assign bus.s_stb       = w_own_stb & ~w_abort;
  assign bus.m0_ack      = w_own0 & (bus.s_ack | w_abort);
  assign bus.m1_ack      = w_own1 & (bus.s_ack | w_abort);
  assign bus.m0_err      = w_own0 & w_abort;
  assign bus.m1_err      = w_own1 & w_abort;
  assign bus.m0_dat_miso = (w_own0 & w_abort) ? ERR_DATA : bus.s_dat_miso;
  assign bus.m1_dat_miso = (w_own1 & w_abort) ? ERR_DATA : bus.s_dat_miso;
  assign bus.grant       = r_grant;
  assign bus.abort_cnt   = r_abort_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_grant     <= 2'b00;
      r_last      <= 1'b1;
      r_wd        <= '0;
      r_abort_cnt <= '0;
    end else begin
      if (!w_own_stb || bus.s_ack || w_abort) begin
        r_wd <= '0;
      end else begin
        r_wd <= r_wd + 1'b1;
      end

      if (w_abort && (r_abort_cnt != 8'hFF)) begin
        r_abort_cnt <= r_abort_cnt + 8'd1;
      end

      // Re-arbitrate when idle or when the owner has closed its bus cycle
      if (!w_own_cyc) begin
        if (bus.m0_cyc && (!bus.m1_cyc || r_last)) begin
          r_state <= ST_OWN0;
          r_grant <= 2'b01;
          r_last  <= 1'b0;
        end else if (bus.m1_cyc) begin
          r_state <= ST_OWN1;
          r_grant <= 2'b10;
          r_last  <= 1'b1;
        end else begin
          r_state <= ST_IDLE;
          r_grant <= 2'b00;
        end
      end
    end
  end
endmodule
`default_nettype wire
